rf_multiport: RTL
=================

Name: rf_multiport

Overview:
- Parametrised successor to the single-cycle core's 16x32 register file.
- Generalised width, depth and read-port count; two write ports with fixed priority; optional write-to-read bypass; optional PC alias on the top address.
- Adds a per-register busy scoreboard for multi-cycle producers (loads, multiply) and a registered write-conflict flag.
- Sits between decode (read/reserve) and writeback (write ports).

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 4, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- PC_ALIAS, 1, 1 = address 2**ADDR_W-1 reads `pc` and is not writable.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- we0  in  1  write enable, port 0 (ALU writeback).
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (load/multicycle writeback; higher priority).
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  packed read data, combinational.
- rbusy  out  NUM_RD  busy bit of each read port's addressed register, combinational.
- pc  in  DATA_W  current program counter, used by the alias.
- rsv_en  in  1  reserve request: mark register busy.
- rsv_addr  in  ADDR_W  register to reserve.
- wr_conflict  out  1  registered; 1 for one cycle after we0 and we1 both targeted the same address.

Behaviour:
- **Storage:** regs[0..2**ADDR_W-1] of DATA_W bits; busy[0..2**ADDR_W-1] of 1 bit.
- **Reset** (posedge clock with reset=1):
  - all regs = 0, all busy = 0, wr_conflict = 0.
  - Reset dominates any simultaneous we0, we1 or rsv_en.
  - While reset is held, rdata reflects zeroed regs from the cycle after the first reset edge; the PC alias still returns pc.
- **Write, per posedge when not in reset:**
  - we0 writes regs[waddr0] = wdata0; we1 writes regs[waddr1] = wdata1.
  - Same address with both enabled: wdata1 is stored.
  - Different addresses: both are stored.
  - Write latency 1: the stored value is visible through the array the cycle after the edge.
- **PC_ALIAS=1:**
  - Writes to address 2**ADDR_W-1 are dropped and the register keeps its value.
  - Reads of that address return pc, overriding array and bypass.
  - busy for that address is never set and rbusy reads 0.
- **Read port i (combinational), priority order:**
  1. PC alias match -> pc.
  2. BYPASS=1 and we1 with waddr1 match -> wdata1.
  3. BYPASS=1 and we0 with waddr0 match -> wdata0.
  4. Otherwise regs[raddr_i].
  - BYPASS=0: the array value only; the new value appears the next cycle.
- **Scoreboard, per posedge when not in reset:**
  - rsv_en sets busy[rsv_addr].
  - A write on either port clears busy[addr].
  - Set and clear on the same address in the same cycle: set wins (a new producer supersedes the completing one).
  - rbusy_i = busy[raddr_i]. rbusy is not bypassed: a register cleared this edge still reads busy until the edge.
- **wr_conflict:** next value = we0 & we1 & (waddr0==waddr1) & ~reset. It is a one-cycle pulse per conflicting cycle, and a level if conflicts repeat.
- **Width rules:** addresses are unsigned; no wrap is possible since depth equals the full address space; data is stored unmodified.

Decomposition:
- Package rf_pkg:
  - default widths;
  - function pc_addr(ADDR_W) returning 2**ADDR_W-1;
  - read-priority encoding constants (SRC_PC, SRC_BYP1, SRC_BYP0, SRC_ARR).
- Sub-module rf_read_mux, instantiated NUM_RD times via generate. Per port it takes the address, array word, busy bit, both write-port buses and pc, and outputs rdata_i and rbusy_i.
- Storage, the scoreboard and the conflict register stay in rf_multiport.

Test Plan:
1. **Reset, then read:** reset 2 cycles, raddr={3,5} -> rdata=0,0; rbusy=0,0; wr_conflict=0; raddr 15 with pc=0x100 -> 0x100.
2. **Dual write, same address:** we0 waddr0=4 wdata0=0xAAAA, we1 waddr1=4 wdata1=0x5555 -> next cycle regs[4]=0x5555, wr_conflict=1 for exactly one cycle, then 0.
3. **Bypass:**
   - BYPASS=1: raddr0=7 with we0 waddr0=7 wdata0=0x1234 same cycle -> rdata0=0x1234 before the edge.
   - Same stimulus with BYPASS=0 -> the old value before the edge, 0x1234 after.
4. **PC alias write:** we1 waddr1=15 wdata1=0xDEAD, pc=0x40 -> regs[15] unchanged; raddr=15 returns 0x40; rbusy=0 even after rsv_en rsv_addr=15.
5. **Scoreboard:**
   - rsv_en addr 9 -> rbusy for raddr 9 = 1 next cycle.
   - we0 addr 9 -> 0 next cycle.
   - rsv_en addr 9 together with we1 addr 9 -> stays 1.
6. **Reset mid-operation:** busy[2]=1, regs[2]=0x77; assert reset with we0 addr 2 data 0x99 and rsv_en addr 3 -> next cycle regs[2]=0, busy all 0, wr_conflict=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults, read-source encoding and address helpers for the
// multi-port register file.
package rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int NUM_RD_DEF = 2;

    typedef enum logic [1:0] {
        SRC_PC   = 2'd0,
        SRC_BYP1 = 2'd1,
        SRC_BYP0 = 2'd2,
        SRC_ARR  = 2'd3
    } rd_src_e;

    // Top address of the register space, used as the program-counter alias.
    function automatic int unsigned pc_addr(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/rf_read_mux.sv
// One read port: chooses between the pc alias, same-cycle write data and
// the stored word, and reports the addressed register's busy bit.
module rf_read_mux
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PC_ALIAS = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              arr_busy,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] rdata,
    output logic              rbusy
);

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(pc_addr(ADDR_W));

    rd_src_e src_s;
    logic    pc_hit_s;

    // Pick the read source in priority order; port 1 outranks port 0.
    always_comb begin
        pc_hit_s = (PC_ALIAS != 0) && (raddr == PC_ADDR);
        if (pc_hit_s) begin
            src_s = SRC_PC;
        end else if ((BYPASS != 0) && we1 && (waddr1 == raddr)) begin
            src_s = SRC_BYP1;
        end else if ((BYPASS != 0) && we0 && (waddr0 == raddr)) begin
            src_s = SRC_BYP0;
        end else begin
            src_s = SRC_ARR;
        end
    end

    // Steer data for the chosen source; busy is never bypassed.
    always_comb begin
        case (src_s)
            SRC_PC:   rdata = pc;
            SRC_BYP1: rdata = wdata1;
            SRC_BYP0: rdata = wdata0;
            SRC_ARR:  rdata = arr_data;
            default:  rdata = arr_data;
        endcase
        rbusy = arr_busy & ~pc_hit_s;
    end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised register file: NUM_RD read ports, two prioritised write
// ports, a per-register busy scoreboard and a registered write-conflict flag.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int PC_ALIAS = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic [DATA_W-1:0]        pc,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     wr_conflict
);

    localparam int                DEPTH   = 32'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(pc_addr(ADDR_W));

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic [DEPTH-1:0]  wr0_s;
    logic [DEPTH-1:0]  wr1_s;
    logic              wr_conflict_r;

    // Per-register write strobes and scoreboard next state; a new reservation
    // beats a completing write to the same register.
    always_comb begin
        wr0_s      = '0;
        wr1_s      = '0;
        busy_nxt_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic writable_v;
            logic set_v;
            writable_v = !((PC_ALIAS != 0) && (ADDR_W'(i) == PC_ADDR));
            wr0_s[i]   = writable_v && we0 && (waddr0 == ADDR_W'(i));
            wr1_s[i]   = writable_v && we1 && (waddr1 == ADDR_W'(i));
            set_v      = writable_v && rsv_en && (rsv_addr == ADDR_W'(i));
            busy_nxt_s[i] = set_v | (busy_r[i] & ~(wr0_s[i] | wr1_s[i]));
        end
    end

    // Register array storage; port 1 wins a same-address collision.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                regs_r[i] <= '0;
            end else if (wr1_s[i]) begin
                regs_r[i] <= wdata1;
            end else if (wr0_s[i]) begin
                regs_r[i] <= wdata0;
            end
        end
    end

    // Scoreboard and conflict flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r        <= '0;
            wr_conflict_r <= 1'b0;
        end else begin
            busy_r        <= busy_nxt_s;
            wr_conflict_r <= we0 & we1 & (waddr0 == waddr1);
        end
    end

    assign wr_conflict = wr_conflict_r;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        assign ra_s = raddr[g*ADDR_W +: ADDR_W];

        rf_read_mux #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .PC_ALIAS(PC_ALIAS),
            .BYPASS  (BYPASS)
        ) u_mux (
            .raddr   (ra_s),
            .arr_data(regs_r[ra_s]),
            .arr_busy(busy_r[ra_s]),
            .we0     (we0),
            .waddr0  (waddr0),
            .wdata0  (wdata0),
            .we1     (we1),
            .waddr1  (waddr1),
            .wdata1  (wdata1),
            .pc      (pc),
            .rdata   (rdata[g*DATA_W +: DATA_W]),
            .rbusy   (rbusy[g])
        );
    end

endmodule
